// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction queue.
// The queue entry layout is the single source of truth for both files.
package branch_resolve_unit_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INCR = 32'd4;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } bru_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_entry_t;

    localparam int ENTRY_W = $bits(pred_entry_t);

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pred_queue.sv
// In-flight prediction FIFO with a single-edge flush; push while full is
// only honoured when a pop happens at the same edge.
module pred_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Flush wins over everything; a full queue accepts a push only alongside a pop.
    assign do_push = push && !flush && (!full || (pop && !empty));
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches EX branch outcomes against queued IF predictions, drives BTB updates,
// fetch redirects and statistics, and blanks the pipeline for a few cycles after a mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pred_push,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        pred_full,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        update_enable,
    output logic [31:0] update_pc,
    output logic [31:0] update_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count,
    output logic        error
);

    localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

    bru_state_t          state;
    logic [RC_W-1:0]     recover_cnt;

    pred_entry_t         push_entry;
    pred_entry_t         head;
    logic [ENTRY_W-1:0]  head_data;
    logic                q_full;
    logic                q_empty;
    logic [$clog2(DEPTH):0] q_count;

    logic                in_run;
    logic                pc_match;
    logic                ex_accept;
    logic                ex_bad;
    logic                mispredict;
    logic                q_push;
    logic                q_pop;
    logic                push_drop;

    assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    assign head       = pred_entry_t'(head_data);
    assign pred_full  = q_full;

    // A resolution only counts when it names the oldest outstanding branch.
    assign in_run     = (state == ST_RUN);
    assign pc_match   = (head.pc == ex_pc);
    assign ex_accept  = in_run && ex_valid && !q_empty && pc_match;
    assign ex_bad     = in_run && ex_valid && (q_empty || !pc_match);
    assign mispredict = ex_accept &&
                        ((head.taken != ex_taken) || (ex_taken && (head.target != ex_target)));

    // Younger entries and a same-cycle push are wrong-path once a mispredict is seen.
    assign q_push     = in_run && pred_push && !mispredict;
    assign q_pop      = ex_accept && !mispredict;
    assign push_drop  = in_run && pred_push && q_full && !ex_accept;

    pred_queue #(
        .DEPTH (DEPTH)
    ) u_pred_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (mispredict),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .head_data (head_data),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_RUN;
            recover_cnt      <= '0;
            update_enable    <= 1'b0;
            update_pc        <= '0;
            update_target    <= '0;
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            error            <= 1'b0;
        end else begin
            update_enable <= ex_accept && ex_taken;
            redirect      <= mispredict;

            if (ex_accept && ex_taken) begin
                update_pc     <= ex_pc;
                update_target <= ex_target;
            end
            if (mispredict) begin
                redirect_pc      <= ex_taken ? ex_target : ex_pc + PC_INCR;
                mispredict_count <= sat_inc16(mispredict_count);
            end
            if (ex_accept) begin
                branch_count <= sat_inc16(branch_count);
            end
            if (ex_bad || push_drop) begin
                error <= 1'b1;
            end

            // RECOVER lasts RECOVER_CYCLES cycles, leaving when the counter sits at 1.
            unique case (state)
                ST_RUN: begin
                    if (mispredict) begin
                        state       <= ST_RECOVER;
                        recover_cnt <= RC_W'(RECOVER_CYCLES);
                    end
                end
                ST_RECOVER: begin
                    if (recover_cnt <= RC_W'(1)) begin
                        state       <= ST_RUN;
                        recover_cnt <= '0;
                    end else begin
                        recover_cnt <= recover_cnt - RC_W'(1);
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    recover_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight prediction queue entries (power of 2).
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2, cycles of RECOVER after a mispredict.
REQ-003 SHALL have ports, clock and reset first: clock input 1, rising-edge clock; reset input 1, reset, asynchronous, active-high.
REQ-004 pred_push input 1, IF records a prediction for a fetched branch; pred_pc input 32; pred_taken input 1; pred_target input 32.
REQ-005 pred_full output 1, queue holds DEPTH entries.
REQ-006 ex_valid input 1, EX resolves oldest branch; ex_pc input 32; ex_taken input 1; ex_target input 32.
REQ-007 update_enable output 1, update_pc output 32, update_target output 32: BTB write port.
REQ-008 redirect output 1, redirect_pc output 32: fetch redirect on mispredict.
REQ-009 branch_count output 16, mispredict_count output 16: saturating statistics.
REQ-010 error output 1, sticky protocol-violation flag.

Function
REQ-011 Queue SHALL be FIFO; push writes {pred_pc, pred_taken, pred_target} at tail; accepted ex_valid pops head.
REQ-012 Mispredict SHALL be (head.taken != ex_taken) or (ex_taken and head.target != ex_target).
REQ-013 All outputs except pred_full SHALL be registered; update/redirect appear exactly 1 cycle after the accepted ex_valid, as single-cycle pulses.
REQ-014 update_enable SHALL pulse when ex_taken=1, with update_pc=ex_pc, update_target=ex_target; not taken -> no update.
REQ-015 redirect SHALL pulse on mispredict; redirect_pc = ex_taken ? ex_target : ex_pc+4 (mod 2^32).
REQ-016 States: RUN, RECOVER. RUN -> RECOVER on mispredict; RECOVER decrements a counter loaded with RECOVER_CYCLES, -> RUN when it reaches 1.
REQ-017 On mispredict the queue SHALL be emptied at the same edge (younger entries are wrong-path); a same-cycle pred_push SHALL be discarded.
REQ-018 In RECOVER, pred_push and ex_valid SHALL be ignored (no push, pop, update, count, or error).
REQ-019 Simultaneous push and pop SHALL be allowed even when full; count unchanged, pointers advance, wrap modulo DEPTH.
REQ-020 Push while full without pop SHALL be dropped and set error.
REQ-021 ex_valid with empty queue, or ex_pc != head.pc, SHALL set error, pop nothing, and produce no update/redirect/count.
REQ-022 branch_count SHALL increment per accepted resolution; mispredict_count per mispredict; both saturate at 16'hFFFF.
REQ-023 pred_full SHALL be combinational from occupancy count (width log2(DEPTH)+1).

Reset
REQ-024 Reset SHALL clear queue (count=0, pointers=0), state=RUN, update_enable=0, update_pc=0, update_target=0, redirect=0, redirect_pc=0, counters=0, error=0.
REQ-025 Reset asserted mid-RECOVER or mid-operation SHALL abandon in-flight entries; no output pulse after reset release until a new accepted resolution.
REQ-026 Only reset clears error.

Structure
REQ-027 Shared package SHALL hold state encoding (RUN, RECOVER), queue-entry field widths, and PC increment constant 4.
REQ-028 Queue SHALL be one sub-module, pred_queue (DEPTH-parameterised FIFO with flush, push, pop, full, empty); the FSM, compare, and counters stay in the top.
REQ-029 update_* outputs SHALL connect directly to the BTB update port without glue logic.

Verification
REQ-030 Push {0x100, taken, 0x200}; ex_valid {0x100, taken, 0x200} -> next cycle update_enable=1 pc 0x100 target 0x200, redirect=0, branch_count=1.
REQ-031 Push {0x104, not-taken}; ex_valid {0x104, taken, 0x300} -> redirect=1 redirect_pc 0x300, update 0x104->0x300, mispredict_count=1, queue empty, 2 cycles of ignored push/ex.
REQ-032 Push {0x108, taken, 0x400}; ex_valid {0x108, not-taken} -> redirect_pc 0x10C, no update; also pc 0xFFFFFFFC not-taken mispredict -> redirect_pc 0x0.
REQ-033 Push 4 entries (full=1), 5th push alone -> dropped, error=1; then same-cycle push+pop -> full stays 1, FIFO order preserved across wrap.
REQ-034 ex_valid with empty queue, and ex_pc mismatch vs head -> error=1, no pulses, counts unchanged.
REQ-035 Assert reset during RECOVER with 3 entries queued -> all outputs 0, pred_full=0, state RUN; counter saturation checked by forcing 65536 resolutions -> branch_count stays 0xFFFF.
